feature_map_writer: RTL and testbench
=====================================

Name: feature_map_writer

Overview:
- Write-side address generator for the on-chip feature-map RAM: the writer counterpart to the padded 3-row column reader used by the conv layer.
- Accepts a raster-ordered pixel stream from a conv/pool output stage and writes each pixel to base_addr + x + ROW_STRIDE*y.
- Optionally zero-fills the destination region before the stream is accepted.
- Sits between a layer's output stage and the single-port feature-map RAM, so the next layer's reader can fetch it.

Parameters:
- DATA_W, 8, pixel width.
- ADDR_W, 13, RAM address width.
- ROW_STRIDE, 64, words per RAM row; power of two.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  single-cycle frame start; sampled only in IDLE.
- clear_en  input  1  zero-fill the region before writing; latched on start.
- base_addr  input  ADDR_W  frame origin; latched on start.
- img_w  input  7  frame width in pixels, 0..127; latched on start.
- img_h  input  7  frame height in rows, 0..127; latched on start.
- in_valid  input  1  stream pixel valid.
- in_data  input  DATA_W  stream pixel.
- in_ready  output  1  block accepts a pixel this cycle.
- wr_en  output  1  RAM write strobe.
- wr_addr  output  ADDR_W  RAM write address.
- wr_data  output  DATA_W  RAM write data.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at frame completion.

Behaviour:
- Reset: synchronous, clk edge with rst=1. State=IDLE, x=y=0. in_ready, wr_en, busy and done are 0. wr_addr=0, wr_data=0. Reset mid-frame aborts the frame with no done pulse.
- All outputs are registered.
- Width clamp: a latched img_w greater than ROW_STRIDE is clamped to ROW_STRIDE.
- Address: base + x + ROW_STRIDE*y, computed in ADDR_W bits, wraps modulo 2^ADDR_W.
- IDLE:
  - start=1 latches the configuration, sets busy=1 and x=y=0.
  - If img_w==0 or img_h==0, go to DONE.
  - Else if clear_en=1, go to CLEAR.
  - Else go to WRITE.
- CLEAR:
  - Every cycle: wr_en=1, wr_data=0, wr_addr=addr(x,y). in_ready=0.
  - Raster advance: x increments; at x=w-1 it wraps to 0 and y increments.
  - The cycle issuing the last address (w-1, h-1) moves the state to WRITE with x=y=0.
  - A clear of W*H words takes exactly W*H cycles.
- WRITE:
  - in_ready=1, including the first cycle after entry.
  - A beat is accepted when in_valid & in_ready.
  - On acceptance, the next cycle has wr_en=1, wr_addr=addr(x,y), wr_data=in_data. Latency is 1 cycle.
  - x/y advance in raster order on each acceptance.
  - When the beat at (w-1, h-1) is accepted, in_ready is 0 from the next cycle and the state moves to DONE.
  - wr_en=0 on cycles with no acceptance. in_valid gaps are allowed.
- DONE:
  - done=1 for exactly one cycle, coincident with the final wr_en when the frame is non-empty.
  - busy is still 1 in this cycle. Next state is IDLE.
- start outside IDLE is ignored. Configuration inputs may change freely after start.
- in_valid asserted outside WRITE is not accepted, and no write occurs.
- Back-to-back frames: start is sampled in the cycle after DONE (first IDLE cycle). Minimum frame-to-frame gap is 2 cycles.

Test Plan:
- 4x3 frame, base=0x100, clear_en=0, in_valid held high with data 1..12:
  - Writes to 0x100..0x103, 0x140..0x143, 0x180..0x183 with data 1..12.
  - done pulses in the cycle of the write to 0x183.
  - in_ready stays low after the 12th accept.
- 2x2 frame, base=0, clear_en=1:
  - Four zero writes to 0, 1, 0x40, 0x41 on consecutive cycles with in_ready=0.
  - Then the stream writes follow in the same order.
- 3x2 frame, in_valid toggling 1,0,1,0:
  - wr_en follows each accept by exactly one cycle.
  - No write occurs on gap cycles; addresses stay contiguous in raster order.
- img_w=0, img_h=5, start:
  - busy for 2 cycles, done pulse, zero writes, in_ready never asserted.
- base=0x1FFF, 2x1 frame:
  - Writes to 0x1FFF then 0x0000 (address wrap).
- Corner cases:
  - Assert rst after 5 of 12 beats: all outputs 0 next cycle, no done pulse.
  - start during WRITE: ignored, and the frame completes normally.
  - img_w=100: each row is clamped to 64 writes.

Source files
------------

// File: rtl/feature_map_writer.sv
// Write-side address generator for the feature-map RAM: optionally zero-fills a
// W x H region, then stores a raster pixel stream at base + x + ROW_STRIDE*y.
module feature_map_writer #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 13,
    parameter int ROW_STRIDE = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clear_en,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [6:0]        img_w,
    input  logic [6:0]        img_h,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    localparam int SHIFT = $clog2(ROW_STRIDE);
    localparam int DIM_W = 8;
    localparam logic [DIM_W-1:0] MAX_W = DIM_W'(ROW_STRIDE);
    localparam logic [DIM_W-1:0] ONE   = DIM_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        WRITE,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [DIM_W-1:0]  w;
    logic [DIM_W-1:0]  h;
    logic [DIM_W-1:0]  x;
    logic [DIM_W-1:0]  y;

    logic [DIM_W-1:0]  x_nxt;
    logic [DIM_W-1:0]  y_nxt;
    logic              at_row_end;
    logic              at_last;
    logic [DIM_W-1:0]  w_clamped;
    logic              frame_empty;

    // NOTE: every signal driven from always_comb gets a default first, so no path leaves it holding a value (no latch).
    always_comb begin
        at_row_end  = (x == w - ONE);
        at_last     = at_row_end && (y == h - ONE);
        x_nxt       = at_row_end ? '0 : x + ONE;
        y_nxt       = at_row_end ? y + ONE : y;
        w_clamped   = (DIM_W'(img_w) > MAX_W) ? MAX_W : DIM_W'(img_w);
        frame_empty = (img_w == 7'd0) || (img_h == 7'd0);
    end

    // Row offset is a shift because ROW_STRIDE is a power of two; the sum wraps in ADDR_W bits.
    function automatic logic [ADDR_W-1:0] addr_of(input logic [DIM_W-1:0] px,
                                                 input logic [DIM_W-1:0] py);
        return base + ADDR_W'(px) + (ADDR_W'(py) << SHIFT);
    endfunction

    // NOTE: all state and outputs use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            base     <= '0;
            w        <= '0;
            h        <= '0;
            x        <= '0;
            y        <= '0;
            in_ready <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            // Strobes default low and are raised only on the cycles that need them.
            wr_en <= 1'b0;
            done  <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        base <= base_addr;
                        w    <= w_clamped;
                        h    <= DIM_W'(img_h);
                        x    <= '0;
                        y    <= '0;
                        busy <= 1'b1;
                        if (frame_empty) begin
                            state <= DONE;
                        end else if (clear_en) begin
                            state   <= CLEAR;
                            wr_en   <= 1'b1;
                            wr_addr <= base_addr;
                            wr_data <= '0;
                        end else begin
                            state    <= WRITE;
                            in_ready <= 1'b1;
                        end
                    end
                end

                CLEAR: begin
                    // x/y name the word being cleared in the current cycle.
                    if (at_last) begin
                        state    <= WRITE;
                        x        <= '0;
                        y        <= '0;
                        in_ready <= 1'b1;
                    end else begin
                        x       <= x_nxt;
                        y       <= y_nxt;
                        wr_en   <= 1'b1;
                        wr_addr <= addr_of(x_nxt, y_nxt);
                        wr_data <= '0;
                    end
                end

                WRITE: begin
                    if (in_valid && in_ready) begin
                        wr_en   <= 1'b1;
                        wr_addr <= addr_of(x, y);
                        wr_data <= in_data;
                        x       <= x_nxt;
                        y       <= y_nxt;
                        if (at_last) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    // Non-empty frames arrive with done already raised; empty ones raise it here.
                    if (done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        done <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_feature_map_writer.sv
// Directed self-checking bench for feature_map_writer: frames, zero-fill, gaps,
// empty frames, address wrap, mid-frame reset, ignored start and width clamp.
module tb_feature_map_writer;

    localparam int DW = 8;
    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          clear_en;
    logic [AW-1:0] base_addr;
    logic [6:0]    img_w;
    logic [6:0]    img_h;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;

    feature_map_writer #(.DATA_W(DW), .ADDR_W(AW), .ROW_STRIDE(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .clear_en (clear_en),
        .base_addr(base_addr),
        .img_w    (img_w),
        .img_h    (img_h),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          dn;
        logic          rdy;
        int            cyc;
    } wr_t;

    wr_t wq[$];
    int  acc_cyc[$];
    int  n_assert = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    int  done_cnt;
    int  busy_cnt;
    int  ready_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and record what the DUT presents in the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (wr_en === 1'b1)
            wq.push_back('{addr: wr_addr, data: wr_data, dn: done, rdy: in_ready, cyc: cyc});
        if (done === 1'b1) done_cnt++;
        if (busy === 1'b1) busy_cnt++;
        if (in_ready === 1'b1) ready_cnt++;
    endtask

    task automatic clear_mon();
        wq.delete();
        acc_cyc.delete();
        done_cnt  = 0;
        busy_cnt  = 0;
        ready_cnt = 0;
    endtask

    task automatic start_frame(input logic [AW-1:0] b, input logic [6:0] w, input logic [6:0] h,
                               input logic clr);
        base_addr = b;
        img_w     = w;
        img_h     = h;
        clear_en  = clr;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        base_addr = 13'h1555;
        img_w     = 7'd127;
        img_h     = 7'd127;
        clear_en  = ~clr;
    endtask

    task automatic send(input logic [DW-1:0] d, input bit gap);
        int guard;
        in_valid = 1'b1;
        in_data  = d;
        guard    = 0;
        while (in_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        chk("ready_wait", 32'(guard < 50), 32'd1);
        acc_cyc.push_back(cyc);
        tick();
        if (gap) begin
            in_valid = 1'b0;
            tick();
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (busy === 1'b1 && guard < 300) begin
            tick();
            guard++;
        end
        chk("idle_wait", 32'(guard < 300), 32'd1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_wr_en"},    32'(wr_en),    32'd0);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_done"},     32'(done),     32'd0);
        chk({tag, "_wr_addr"},  32'(wr_addr),  32'd0);
        chk({tag, "_wr_data"},  32'(wr_data),  32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        clear_en  = 1'b0;
        base_addr = '0;
        img_w     = '0;
        img_h     = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        clear_mon();
        repeat (3) tick();
        chk_outputs_zero("reset");
        rst = 1'b0;
        tick();

        // 4x3 frame at 0x100, continuous stream 1..12.
        clear_mon();
        start_frame(13'h100, 7'd4, 7'd3, 1'b0);
        for (int k = 1; k <= 12; k++) send(DW'(k), 1'b0);
        repeat (3) tick();
        in_valid = 1'b0;
        chk("t1_count", wq.size(), 32'd12);
        for (int k = 0; k < 12; k++) begin
            if (k < wq.size()) begin
                chk($sformatf("t1_addr%0d", k), 32'(wq[k].addr), 32'h100 + (k % 4) + 64 * (k / 4));
                chk($sformatf("t1_data%0d", k), 32'(wq[k].data), 32'(k + 1));
                chk($sformatf("t1_done%0d", k), 32'(wq[k].dn), 32'(k == 11));
            end
        end
        if (wq.size() == 12) chk("t1_ready_after_last", 32'(wq[11].rdy), 32'd0);
        chk("t1_done_cnt", done_cnt, 32'd1);
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk("t1_ready_end", 32'(in_ready), 32'd0);

        // 2x2 frame with zero-fill; in_valid is already high during the clear.
        clear_mon();
        in_valid = 1'b1;
        in_data  = 8'hEE;
        start_frame(13'h000, 7'd2, 7'd2, 1'b1);
        for (int k = 0; k < 4; k++) send(8'hA1 + DW'(k), 1'b0);
        in_valid = 1'b0;
        wait_idle();
        chk("t2_count", wq.size(), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < wq.size()) begin
                chk($sformatf("t2_addr%0d", k), 32'(wq[k].addr), 32'((k % 2) + 64 * ((k % 4) / 2)));
                chk($sformatf("t2_data%0d", k), 32'(wq[k].data), (k < 4) ? 32'd0 : 32'hA1 + 32'(k - 4));
                if (k < 4) begin
                    chk($sformatf("t2_clr_rdy%0d", k), 32'(wq[k].rdy), 32'd0);
                    chk($sformatf("t2_clr_cyc%0d", k), 32'(wq[k].cyc - wq[0].cyc), 32'(k));
                end
            end
        end
        chk("t2_done_cnt", done_cnt, 32'd1);

        // 3x2 frame with in_valid toggling every cycle.
        clear_mon();
        start_frame(13'h200, 7'd3, 7'd2, 1'b0);
        for (int k = 0; k < 6; k++) send(8'h30 + DW'(k), 1'b1);
        in_valid = 1'b0;
        wait_idle();
        chk("t3_count", wq.size(), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < wq.size()) begin
                chk($sformatf("t3_addr%0d", k), 32'(wq[k].addr), 32'h200 + (k % 3) + 64 * (k / 3));
                chk($sformatf("t3_data%0d", k), 32'(wq[k].data), 32'h30 + 32'(k));
                chk($sformatf("t3_lat%0d", k), 32'(wq[k].cyc - acc_cyc[k]), 32'd1);
            end
        end
        chk("t3_done_cnt", done_cnt, 32'd1);

        // Empty frame: img_w=0.
        clear_mon();
        in_valid = 1'b1;
        start_frame(13'h055, 7'd0, 7'd5, 1'b1);
        repeat (4) tick();
        in_valid = 1'b0;
        chk("t4_busy_cycles", busy_cnt, 32'd2);
        chk("t4_done_cnt", done_cnt, 32'd1);
        chk("t4_writes", wq.size(), 32'd0);
        chk("t4_ready_cycles", ready_cnt, 32'd0);

        // Address wrap from 0x1FFF.
        clear_mon();
        start_frame(13'h1FFF, 7'd2, 7'd1, 1'b0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        in_valid = 1'b0;
        wait_idle();
        chk("t5_count", wq.size(), 32'd2);
        if (wq.size() == 2) begin
            chk("t5_addr0", 32'(wq[0].addr), 32'h1FFF);
            chk("t5_addr1", 32'(wq[1].addr), 32'h0000);
            chk("t5_data1", 32'(wq[1].data), 32'h22);
            chk("t5_done1", 32'(wq[1].dn), 32'd1);
        end

        // Reset after 5 of 12 beats.
        clear_mon();
        start_frame(13'h100, 7'd4, 7'd3, 1'b0);
        for (int k = 1; k <= 5; k++) send(DW'(k), 1'b0);
        rst = 1'b1;
        tick();
        chk_outputs_zero("t6_rst");
        rst = 1'b0;
        repeat (3) tick();
        in_valid = 1'b0;
        chk("t6_writes", wq.size(), 32'd5);
        chk("t6_done_cnt", done_cnt, 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);

        // start during WRITE is ignored.
        clear_mon();
        start_frame(13'h300, 7'd3, 7'd2, 1'b0);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        start     = 1'b1;
        base_addr = 13'h010;
        img_w     = 7'd5;
        img_h     = 7'd1;
        clear_en  = 1'b1;
        send(8'h03, 1'b0);
        start = 1'b0;
        for (int k = 4; k <= 6; k++) send(DW'(k), 1'b0);
        in_valid = 1'b0;
        wait_idle();
        repeat (2) tick();
        chk("t7_count", wq.size(), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < wq.size())
                chk($sformatf("t7_addr%0d", k), 32'(wq[k].addr), 32'h300 + (k % 3) + 64 * (k / 3));
        end
        chk("t7_done_cnt", done_cnt, 32'd1);
        chk("t7_stays_idle", 32'(busy), 32'd0);

        // img_w=100 is clamped to 64 words per row.
        clear_mon();
        start_frame(13'h000, 7'd100, 7'd2, 1'b0);
        for (int k = 0; k < 128; k++) send(DW'(k), 1'b0);
        in_valid = 1'b0;
        wait_idle();
        chk("t8_count", wq.size(), 32'd128);
        for (int k = 0; k < 128; k++) begin
            if (k < wq.size()) begin
                chk($sformatf("t8_addr%0d", k), 32'(wq[k].addr), 32'(k));
                chk($sformatf("t8_data%0d", k), 32'(wq[k].data), 32'(k));
            end
        end
        chk("t8_done_cnt", done_cnt, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
